// File: rtl/fir_filter_mc_serial.sv
// Multi-channel time-shared symmetric/anti-symmetric FIR: one pre-adder, multiplier and accumulator
// serve all channels. Define FIR_MC_SATURATE_EN to saturate the output instead of wrapping it.
module fir_filter_mc_serial #(
  parameter int INPUT_WIDTH  = 16,
  parameter int COEFF_WIDTH  = 16,
  parameter int NUM_TAPS     = 31,
  parameter int NUM_CHANNELS = 4,
  parameter int SYMMETRY     = 0,
  parameter int OUTPUT_WIDTH = 24,
  parameter int OUT_SHIFT    = 15,
  parameter logic [((NUM_TAPS+1)/2)*COEFF_WIDTH-1:0] COEFFS =
    {{(((NUM_TAPS+1)/2)*COEFF_WIDTH-1){1'b0}}, 1'b1} << (((NUM_TAPS+1)/2-1)*COEFF_WIDTH + COEFF_WIDTH-2)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [INPUT_WIDTH-1:0]  s_data,
  input  logic [(NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1)-1:0] s_chan,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [OUTPUT_WIDTH-1:0] m_data,
  output logic [(NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1)-1:0] m_chan,
  input  logic                    coef_we,
  input  logic [(((NUM_TAPS+1)/2) > 1 ? $clog2((NUM_TAPS+1)/2) : 1)-1:0] coef_addr,
  input  logic [COEFF_WIDTH-1:0]  coef_data,
  output logic                    coef_busy
);
  localparam int K      = (NUM_TAPS + 1) / 2;
  localparam int CHW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int KW     = (K > 1) ? $clog2(K) : 1;
  localparam int TAP_W  = $clog2(NUM_TAPS);
  localparam int PRE_W  = INPUT_WIDTH + 1;
  localparam int PROD_W = INPUT_WIDTH + COEFF_WIDTH + 1;
  localparam int ACC_W  = PROD_W + $clog2(K);
  localparam int R_W    = ACC_W + OUTPUT_WIDTH + 1;
  localparam bit ODD_TAPS = (NUM_TAPS % 2) == 1;
  localparam logic signed [R_W-1:0] RND = (R_W'(1) << OUT_SHIFT) >> 1;

  typedef enum logic [1:0] {IDLE, MAC, FLUSH, OUT} state_t;

  state_t                          state_q, state_d;
  logic [KW-1:0]                   k_q, k_d;
  logic [CHW-1:0]                  chan_q, chan_d;
  logic signed [ACC_W-1:0]         acc_q, acc_d;
  logic signed [PROD_W-1:0]        prod_q, prod_d;
  logic [OUTPUT_WIDTH-1:0]         m_data_q, m_data_d;
  logic [CHW-1:0]                  m_chan_q, m_chan_d;
  logic signed [INPUT_WIDTH-1:0]   x_q [NUM_CHANNELS][NUM_TAPS];
  logic signed [INPUT_WIDTH-1:0]   x_d [NUM_CHANNELS][NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0]   coef_q [K];
  logic signed [COEFF_WIDTH-1:0]   coef_d [K];

  logic                            chan_ok, coef_addr_ok, centre;
  logic [TAP_W-1:0]                tap_lo, tap_hi;
  logic signed [INPUT_WIDTH-1:0]   xa, xb;
  logic signed [PRE_W-1:0]         pre;
  logic signed [PROD_W-1:0]        prod_mac;
  logic signed [ACC_W-1:0]         acc_sum;
  logic signed [R_W-1:0]           r_full;
  logic [OUTPUT_WIDTH-1:0]         r_fmt;

  assign chan_ok      = 32'(s_chan) < NUM_CHANNELS;
  assign coef_addr_ok = 32'(coef_addr) < K;

  // Tap k pairs with its mirror N-1-k; the centre tap of an odd-length filter has no partner.
  assign tap_lo   = TAP_W'(k_q);
  assign tap_hi   = TAP_W'(NUM_TAPS - 1) - tap_lo;
  assign xa       = x_q[chan_q][tap_lo];
  assign xb       = x_q[chan_q][tap_hi];
  assign centre   = ODD_TAPS && (k_q == KW'(K - 1));
  assign pre      = centre ? PRE_W'(xa)
                  : (SYMMETRY != 0) ? PRE_W'(xa) - PRE_W'(xb)
                  : PRE_W'(xa) + PRE_W'(xb);
  assign prod_mac = PROD_W'(pre) * PROD_W'(coef_q[k_q]);
  assign acc_sum  = acc_q + ACC_W'(prod_q);
  assign r_full   = (R_W'(acc_sum) + RND) >>> OUT_SHIFT;

`ifdef FIR_MC_SATURATE_EN
  localparam logic signed [R_W-1:0] SAT_MAX = (R_W'(1) << (OUTPUT_WIDTH - 1)) - R_W'(1);
  localparam logic signed [R_W-1:0] SAT_MIN = -(R_W'(1) << (OUTPUT_WIDTH - 1));
  assign r_fmt = (r_full > SAT_MAX) ? SAT_MAX[OUTPUT_WIDTH-1:0]
               : (r_full < SAT_MIN) ? SAT_MIN[OUTPUT_WIDTH-1:0]
               : r_full[OUTPUT_WIDTH-1:0];
`else
  assign r_fmt = r_full[OUTPUT_WIDTH-1:0];
`endif

  assign s_ready   = (state_q == IDLE);
  assign coef_busy = (state_q != IDLE);
  assign m_valid   = (state_q == OUT);
  assign m_data    = m_data_q;
  assign m_chan    = m_chan_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    k_d      = k_q;
    chan_d   = chan_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    m_data_d = m_data_q;
    m_chan_d = m_chan_q;
    x_d      = x_q;
    coef_d   = coef_q;
    case (state_q)
      IDLE: begin
        if (coef_we && coef_addr_ok) coef_d[coef_addr] = coef_data;
        if (s_valid && chan_ok) begin
          for (int i = NUM_TAPS - 1; i > 0; i--) x_d[s_chan][i] = x_q[s_chan][i-1];
          x_d[s_chan][0] = $signed(s_data);
          chan_d  = s_chan;
          acc_d   = '0;
          prod_d  = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        prod_d = prod_mac;
        acc_d  = acc_sum;
        if (k_q == KW'(K - 1)) state_d = FLUSH;
        else                   k_d     = k_q + 1'b1;
      end
      FLUSH: begin
        acc_d    = acc_sum;
        m_data_d = r_fmt;
        m_chan_d = chan_q;
        state_d  = OUT;
      end
      OUT: if (m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      chan_q   <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      m_data_q <= '0;
      m_chan_q <= '0;
      // NOTE: delay lines and coefficients are reset so no stale history leaks into post-reset outputs.
      for (int c = 0; c < NUM_CHANNELS; c++)
        for (int t = 0; t < NUM_TAPS; t++) x_q[c][t] <= '0;
      for (int i = 0; i < K; i++) coef_q[i] <= COEFFS[i*COEFF_WIDTH +: COEFF_WIDTH];
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
      state_q  <= state_d;
      k_q      <= k_d;
      chan_q   <= chan_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      m_data_q <= m_data_d;
      m_chan_q <= m_chan_d;
      x_q      <= x_d;
      coef_q   <= coef_d;
    end
  end
endmodule

// File: tb/tb_fir_filter_mc_serial.sv
// Self-checking bench for fir_filter_mc_serial: directed impulse/isolation/backpressure/reload/reset
// steps plus random traffic against a direct-form FIR model; a second 8-bit-output instance checks wrap/saturation.
module tb_fir_filter_mc_serial;
  localparam int NT  = 5;
  localparam int NC  = 2;
  localparam int KC  = 3;
  localparam int OWA = 24;
  localparam int OWB = 8;
  localparam int OS  = 0;
  localparam logic [47:0] TB_COEFFS = 48'h0003_0002_0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic s_valid = 0, s_ready, m_valid, m_ready = 0, coef_we = 0, coef_busy;
  logic [15:0] s_data = '0, coef_data = '0;
  logic [0:0] s_chan = '0, m_chan;
  logic [1:0] coef_addr = '0;
  logic [OWA-1:0] m_data;

  logic b_s_valid = 0, b_s_ready, b_m_valid, b_coef_busy;
  logic [15:0] b_s_data = '0;
  logic [0:0] b_m_chan;
  logic [OWB-1:0] b_m_data;

  fir_filter_mc_serial #(
    .INPUT_WIDTH(16), .COEFF_WIDTH(16), .NUM_TAPS(NT), .NUM_CHANNELS(NC), .SYMMETRY(0),
    .OUTPUT_WIDTH(OWA), .OUT_SHIFT(OS), .COEFFS(TB_COEFFS)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_chan(s_chan),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_chan(m_chan),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_busy(coef_busy)
  );

  fir_filter_mc_serial #(
    .INPUT_WIDTH(16), .COEFF_WIDTH(16), .NUM_TAPS(NT), .NUM_CHANNELS(NC), .SYMMETRY(0),
    .OUTPUT_WIDTH(OWB), .OUT_SHIFT(OS), .COEFFS(TB_COEFFS)
  ) dut_b (
    .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_chan(1'b0),
    .m_valid(b_m_valid), .m_ready(1'b1), .m_data(b_m_data), .m_chan(b_m_chan),
    .coef_we(1'b0), .coef_addr(2'b00), .coef_data(16'h0000), .coef_busy(b_coef_busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  longint mx [NC][NT];
  longint mc [KC];
  longint bx [NT];
  longint got;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Direct-form FIR: expand the half coefficient set into the full impulse response.
  function automatic longint fir(input longint x [NT], input longint c [KC]);
    longint h [NT];
    longint acc;
    acc = 0;
    for (int i = 0; i < KC; i++) begin
      h[i] = c[i];
      h[NT-1-i] = c[i];
    end
    for (int i = 0; i < NT; i++) acc += h[i] * x[i];
    return (acc + ((longint'(1) << OS) >>> 1)) >>> OS;
  endfunction

  function automatic longint fmt(input longint r, input int w);
`ifdef FIR_MC_SATURATE_EN
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    return (r > hi) ? hi : (r < lo) ? lo : r;
`else
    return (r <<< (64 - w)) >>> (64 - w);
`endif
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++)
      for (int t = 0; t < NT; t++) mx[c][t] = 0;
    mc[0] = 1; mc[1] = 2; mc[2] = 3;
  endtask

  task automatic wr_coef(input int a, input int v);
    @(negedge clk);
    check("coef_busy_idle", coef_busy, 0);
    coef_we = 1; coef_addr = a[1:0]; coef_data = v[15:0];
    @(posedge clk);
    if (a < KC) mc[a] = v;
    @(negedge clk);
    coef_we = 0;
  endtask

  task automatic send(input int ch, input int d, input int hold,
                      input bit cw_now, input int cw_addr, input int cw_data, input bit cw_mac);
    int n;
    longint row [NT];
    longint expv;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 40) begin @(negedge clk); n++; end
    check("s_ready_before_send", s_ready, 1);
    s_valid = 1; s_chan = ch[0:0]; s_data = d[15:0];
    if (cw_now) begin coef_we = 1; coef_addr = cw_addr[1:0]; coef_data = cw_data[15:0]; end
    @(posedge clk);
    if (cw_now && cw_addr < KC) mc[cw_addr] = cw_data;
    for (int i = NT - 1; i > 0; i--) mx[ch][i] = mx[ch][i-1];
    mx[ch][0] = d;
    for (int i = 0; i < NT; i++) row[i] = mx[ch][i];
    expv = fmt(fir(row, mc), OWA);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      s_valid = 0; coef_we = 0;
      if (cw_mac && n == 1) begin
        check("coef_busy_mac", coef_busy, 1);
        coef_we = 1; coef_addr = cw_addr[1:0]; coef_data = cw_data[15:0];
      end
    end while (!m_valid && n < 30);
    check("latency", n, KC + 2);
    got = longint'($signed(m_data));
    check("m_data", $signed(m_data), expv);
    check("m_chan", m_chan, ch);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_s_ready", s_ready, 0);
      check("bp_m_valid", m_valid, 1);
      check("bp_m_data", $signed(m_data), expv);
    end
    m_ready = 1;
    @(negedge clk);
    m_ready = 0;
    check("post_m_valid", m_valid, 0);
    check("post_s_ready", s_ready, 1);
  endtask

  task automatic send_b(input int d);
    int n;
    longint expv;
    longint cb [KC];
    cb[0] = 1; cb[1] = 2; cb[2] = 3;
    n = 0;
    @(negedge clk);
    while (!b_s_ready && n < 40) begin @(negedge clk); n++; end
    b_s_valid = 1; b_s_data = d[15:0];
    @(posedge clk);
    for (int i = NT - 1; i > 0; i--) bx[i] = bx[i-1];
    bx[0] = d;
    expv = fmt(fir(bx, cb), OWB);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      b_s_valid = 0;
    end while (!b_m_valid && n < 30);
    check("b_latency", n, KC + 2);
    check("b_m_data", $signed(b_m_data), expv);
  endtask

  initial begin
    int imp [6];
    int iso1 [5];
    int rel [5];
    int ch, d, a, v, hold, highs;
    bit cwn, cwm;
    imp  = '{1, 2, 3, 2, 1, 0};
    iso1 = '{100, 300, 600, 800, 900};
    rel  = '{1, 2, -4, 2, 1};
    model_reset();
    for (int i = 0; i < NT; i++) bx[i] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_chan", m_chan, 0);
    check("rst_coef_busy", coef_busy, 0);

    // Impulse on channel 0
    for (int i = 0; i < 6; i++) begin
      send(0, (i == 0) ? 1 : 0, 0, 0, 0, 0, 0);
      check("impulse_const", got, imp[i]);
    end

    // Channel isolation
    for (int i = 0; i < 5; i++) begin
      send(0, (i == 0) ? 1 : 0, 0, 0, 0, 0, 0);
      check("iso_ch0_const", got, imp[i]);
      send(1, 100, 0, 0, 0, 0, 0);
      check("iso_ch1_const", got, iso1[i]);
    end

    // Backpressure
    send(0, 7, 10, 0, 0, 0, 0);

    // Coefficient reload; out-of-range and mid-MAC writes ignored
    for (int i = 0; i < NT; i++) send(0, 0, 0, 0, 0, 0, 0);
    wr_coef(2, -4);
    wr_coef(3, 99);
    for (int i = 0; i < 5; i++) begin
      send(0, (i == 0) ? 1 : 0, 0, 0, 0, 50, i == 0);
      check("reload_const", got, rel[i]);
    end

    // Reset during MAC
    @(negedge clk);
    s_valid = 1; s_chan = 1'b0; s_data = 16'd5;
    @(posedge clk);
    @(negedge clk);
    s_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_valid) highs++;
    end
    check("rst_mac_no_output", highs, 0);
    check("rst_mac_s_ready", s_ready, 1);
    for (int i = 0; i < 5; i++) begin
      send(0, (i == 0) ? 1 : 0, 0, 0, 0, 0, 0);
      check("post_rst_const", got, imp[i]);
    end

    // Random traffic, coefficient writes and backpressure
    for (int i = 0; i < 40; i++) begin
      ch   = int'($urandom_range(0, 1));
      d    = int'($urandom_range(0, 65535)) - 32768;
      a    = int'($urandom_range(0, 3));
      v    = int'($urandom_range(0, 65535)) - 32768;
      hold = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) wr_coef(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)) - 32768);
      cwn = ($urandom_range(0, 3) == 0);
      cwm = !cwn && ($urandom_range(0, 4) == 0);
      send(ch, d, hold, cwn, a, v, cwm);
    end

    // Narrow output: wrap or saturate
    for (int i = 0; i < 6; i++) send_b(32767);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
